// File: rtl/hi_reader_sequencer_if.sv
// Bundle of command, configuration, report and status signals between the
// ARM-facing register block, the HF reader datapath and the sequencer.
interface hi_reader_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             cfg_shallow;
    logic             cfg_amp_rx;
    logic [1:0]       cfg_subcarrier;
    logic [CNT_W-1:0] cfg_tx_cycles;
    logic [CNT_W-1:0] cfg_guard_cycles;
    logic [CNT_W-1:0] cfg_timeout_cycles;
    logic [7:0]       cfg_threshold;
    logic [3:0]       cfg_quiet_reports;
    logic [7:0]       corr_amp;
    logic             corr_valid;
    logic [3:0]       minor_mode;
    logic [1:0]       subcarrier_frequency;
    logic             busy;
    logic             rx_gate;
    logic             done;
    logic             status_tag_seen;
    logic             status_timeout;

    // Controller side: issues commands/config, supplies reports, reads status.
    modport master (
        output start, abort, cfg_shallow, cfg_amp_rx, cfg_subcarrier,
               cfg_tx_cycles, cfg_guard_cycles, cfg_timeout_cycles,
               cfg_threshold, cfg_quiet_reports, corr_amp, corr_valid,
        input  minor_mode, subcarrier_frequency, busy, rx_gate, done,
               status_tag_seen, status_timeout
    );

    // Sequencer side.
    modport slave (
        input  start, abort, cfg_shallow, cfg_amp_rx, cfg_subcarrier,
               cfg_tx_cycles, cfg_guard_cycles, cfg_timeout_cycles,
               cfg_threshold, cfg_quiet_reports, corr_amp, corr_valid,
        output minor_mode, subcarrier_frequency, busy, rx_gate, done,
               status_tag_seen, status_timeout
    );
endinterface

// File: rtl/hi_reader_sequencer.sv
// HF reader transaction sequencer: walks TX -> GUARD -> RX (-> RESP) and back
// to IDLE, steering the datapath minor_mode and watching amplitude reports
// for a tag response. All logic runs on the falling edge of the carrier clock
// so it lines up with the datapath's own sampling.
module hi_reader_sequencer #(
    parameter logic [3:0] MODE_RECEIVE_IQ        = 4'd0,
    parameter logic [3:0] MODE_RECEIVE_AMPLITUDE = 4'd1,
    parameter logic [3:0] MODE_SEND_FULL_MOD     = 4'd3,
    parameter logic [3:0] MODE_SEND_SHALLOW_MOD  = 4'd4,
    parameter int         CNT_W                  = 16
) (
    input logic                   ck_1356meg,
    input logic                   reset,
    hi_reader_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TX    = 3'd1,
        ST_GUARD = 3'd2,
        ST_RX    = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Zero-length phases still last one cycle.
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
        eff_len = (len == {CNT_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : len;
    endfunction

    function automatic logic [3:0] eff_quiet(input logic [3:0] len);
        eff_quiet = (len == 4'd0) ? 4'd1 : len;
    endfunction

    // Counters hold at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        sat_inc4 = (v == 4'hF) ? v : v + 4'd1;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [3:0]       quiet_r;
    logic [3:0]       quiet_next_s;
    logic             latch_s;
    logic             set_tag_s;
    logic             set_timeout_s;
    logic             shallow_eff_s;
    logic             amp_rx_eff_s;

    logic             shallow_r;
    logic             amp_rx_r;
    logic [1:0]       subcarrier_r;
    logic [CNT_W-1:0] tx_len_r;
    logic [CNT_W-1:0] guard_len_r;
    logic [CNT_W-1:0] timeout_len_r;
    logic [7:0]       threshold_r;
    logic [3:0]       quiet_len_r;

    logic [3:0]       minor_mode_r;
    logic             busy_r;
    logic             rx_gate_r;
    logic             done_r;
    logic             tag_seen_r;
    logic             timeout_flag_r;

    // Mode presented to the datapath while a given state is active.
    function automatic logic [3:0] mode_for(input state_t st, input logic shallow,
                                            input logic amp_rx);
        case (st)
            ST_TX:                    mode_for = shallow ? MODE_SEND_SHALLOW_MOD : MODE_SEND_FULL_MOD;
            ST_GUARD, ST_RX, ST_RESP: mode_for = amp_rx ? MODE_RECEIVE_AMPLITUDE : MODE_RECEIVE_IQ;
            default:                  mode_for = MODE_RECEIVE_IQ;
        endcase
    endfunction

    // Next-state, counter and status-event decode; abort always wins.
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        quiet_next_s  = quiet_r;
        latch_s       = 1'b0;
        set_tag_s     = 1'b0;
        set_timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_next_s = ST_TX;
                    cnt_next_s   = {CNT_W{1'b0}};
                    quiet_next_s = 4'd0;
                    latch_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_TX: begin
                if (bus.abort) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else if (sat_inc(cnt_r) >= eff_len(tx_len_r)) begin
                    state_next_s = ST_GUARD;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_next_s   = sat_inc(cnt_r);
                end
            end
            ST_GUARD: begin
                if (bus.abort) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else if (sat_inc(cnt_r) >= eff_len(guard_len_r)) begin
                    state_next_s = ST_RX;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_next_s   = sat_inc(cnt_r);
                end
            end
            ST_RX: begin
                if (bus.abort) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else if (bus.corr_valid && (bus.corr_amp >= threshold_r)) begin
                    state_next_s = ST_RESP;
                    cnt_next_s   = {CNT_W{1'b0}};
                    quiet_next_s = 4'd0;
                    set_tag_s    = 1'b1;
                end else if (sat_inc(cnt_r) >= eff_len(timeout_len_r)) begin
                    state_next_s  = ST_IDLE;
                    cnt_next_s    = {CNT_W{1'b0}};
                    set_timeout_s = 1'b1;
                end else begin
                    cnt_next_s    = sat_inc(cnt_r);
                end
            end
            ST_RESP: begin
                if (bus.abort) begin
                    state_next_s = ST_IDLE;
                    quiet_next_s = 4'd0;
                end else if (bus.corr_valid) begin
                    if (bus.corr_amp >= threshold_r) begin
                        quiet_next_s = 4'd0;
                    end else if (sat_inc4(quiet_r) >= eff_quiet(quiet_len_r)) begin
                        state_next_s = ST_IDLE;
                        quiet_next_s = 4'd0;
                    end else begin
                        quiet_next_s = sat_inc4(quiet_r);
                    end
                end else begin
                    quiet_next_s = quiet_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
                quiet_next_s = 4'd0;
            end
        endcase
    end

    // On the start edge the mode must come from the live cfg, not the old latch.
    always_comb begin
        if (latch_s) begin
            shallow_eff_s = bus.cfg_shallow;
            amp_rx_eff_s  = bus.cfg_amp_rx;
        end else begin
            shallow_eff_s = shallow_r;
            amp_rx_eff_s  = amp_rx_r;
        end
    end

    // State and phase counters.
    always_ff @(negedge ck_1356meg) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            quiet_r <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            quiet_r <= quiet_next_s;
        end
    end

    // Transaction configuration, captured once at start.
    always_ff @(negedge ck_1356meg) begin
        if (reset) begin
            shallow_r     <= 1'b0;
            amp_rx_r      <= 1'b0;
            subcarrier_r  <= 2'b00;
            tx_len_r      <= {CNT_W{1'b0}};
            guard_len_r   <= {CNT_W{1'b0}};
            timeout_len_r <= {CNT_W{1'b0}};
            threshold_r   <= 8'd0;
            quiet_len_r   <= 4'd0;
        end else if (latch_s) begin
            shallow_r     <= bus.cfg_shallow;
            amp_rx_r      <= bus.cfg_amp_rx;
            subcarrier_r  <= bus.cfg_subcarrier;
            tx_len_r      <= bus.cfg_tx_cycles;
            guard_len_r   <= bus.cfg_guard_cycles;
            timeout_len_r <= bus.cfg_timeout_cycles;
            threshold_r   <= bus.cfg_threshold;
            quiet_len_r   <= bus.cfg_quiet_reports;
        end else begin
            shallow_r     <= shallow_r;
        end
    end

    // Registered outputs derived from the state being entered.
    always_ff @(negedge ck_1356meg) begin
        if (reset) begin
            minor_mode_r <= MODE_RECEIVE_IQ;
            busy_r       <= 1'b0;
            rx_gate_r    <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            minor_mode_r <= mode_for(state_next_s, shallow_eff_s, amp_rx_eff_s);
            busy_r       <= (state_next_s != ST_IDLE);
            rx_gate_r    <= (state_next_s == ST_RX) || (state_next_s == ST_RESP);
            done_r       <= (state_r != ST_IDLE) && (state_next_s == ST_IDLE);
        end
    end

    // Sticky per-transaction status, cleared when a new transaction starts.
    always_ff @(negedge ck_1356meg) begin
        if (reset) begin
            tag_seen_r     <= 1'b0;
            timeout_flag_r <= 1'b0;
        end else if (latch_s) begin
            tag_seen_r     <= 1'b0;
            timeout_flag_r <= 1'b0;
        end else begin
            tag_seen_r     <= tag_seen_r | set_tag_s;
            timeout_flag_r <= timeout_flag_r | set_timeout_s;
        end
    end

    assign bus.minor_mode           = minor_mode_r;
    assign bus.subcarrier_frequency = subcarrier_r;
    assign bus.busy                 = busy_r;
    assign bus.rx_gate              = rx_gate_r;
    assign bus.done                 = done_r;
    assign bus.status_tag_seen      = tag_seen_r;
    assign bus.status_timeout       = timeout_flag_r;

endmodule
